// File: rtl/param_sap_cpu.sv
// ---------------------------------------------------------------------------
// param_sap_cpu : parameterised SAP-1 style accumulator CPU with on-chip RAM.
// Define PARAM_SAP_CPU_BRANCH_EN to enable JC/JZ.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_sap_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic              cf,
  output logic              zf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_EX1  = 3'd3,
    S_EX2  = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
`ifdef PARAM_SAP_CPU_BRANCH_EN
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
`endif
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                cf_q, cf_d;
  logic                zf_q, zf_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   ram_q [2**ADDR_W];

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   mem_rd;
  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                is_sub;
  logic [DATA_W-1:0]   b_op;
  logic [DATA_W:0]     sum;

  assign mem_rd  = ram_q[mar_q];
  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign is_sub  = (opcode == OP_SUB);
  // SUB is A + ~B + 1, so the carry out reads as "no borrow".
  assign b_op    = is_sub ? ~mem_rd : mem_rd;
  assign sum     = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    cf_d        = cf_q;
    zf_d        = zf_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = mar_q;
    ram_wdata   = a_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (prog_we) begin
          ram_we    = 1'b1;
          ram_waddr = prog_addr;
          ram_wdata = prog_data;
        end
        if (run) begin
          pc_d    = '0;
          a_d     = '0;
          b_d     = '0;
          cf_d    = 1'b0;
          zf_d    = 1'b0;
          state_d = S_F1;
        end
      end
      S_F1: begin
        mar_d   = pc_q;
        state_d = S_F2;
      end
      S_F2: begin
        ir_d    = mem_rd;
        pc_d    = pc_q + 1'b1;
        state_d = S_EX1;
      end
      S_EX1: begin
        state_d = S_F1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = operand;
            state_d = S_EX2;
          end
          OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
          OP_JMP: pc_d = operand;
`ifdef PARAM_SAP_CPU_BRANCH_EN
          OP_JC:  if (cf_q) pc_d = operand;
          OP_JZ:  if (zf_q) pc_d = operand;
`endif
          OP_OUT: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_EX2: begin
        state_d = S_F1;
        case (opcode)
          OP_LDA: a_d = mem_rd;
          OP_ADD, OP_SUB: begin
            b_d  = mem_rd;
            a_d  = sum[DATA_W-1:0];
            cf_d = sum[DATA_W];
            zf_d = (sum[DATA_W-1:0] == '0);
          end
          OP_STA: ram_we = 1'b1;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM is never cleared; a reset edge also suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign cf        = cf_q;
  assign zf        = zf_q;

endmodule

`default_nettype wire

// File: tb/tb_param_sap_cpu.sv
// ---------------------------------------------------------------------------
// tb_param_sap_cpu : directed, scoreboard-checked bench for param_sap_cpu.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_param_sap_cpu;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int LIMIT  = 200;

  logic              clk;
  logic              rst;
  logic              run;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              halted;
  logic              cf;
  logic              zf;

  int vectors     = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] sb [$];

  param_sap_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .halted    (halted),
    .cf        (cf),
    .zf        (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every out_valid pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic write_ram(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  task automatic load4(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                       input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
    write_ram(4'd0, w0);
    write_ram(4'd1, w1);
    write_ram(4'd2, w2);
    write_ram(4'd3, w3);
  endtask

  // inj < 0 : program write coincides with the run pulse.
  // inj >= 0: write + run re-issued while busy, driven after edge inj.
  task automatic run_prog(input int inj, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int edges);
    @(negedge clk);
    run = 1'b1;
    if (inj < 0) begin
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
    end
    @(posedge clk);
    #1;
    run     = 1'b0;
    prog_we = 1'b0;
    edges   = 0;
    while (!halted && edges < LIMIT) begin
      if (edges == inj) begin
        prog_we   = 1'b1;
        run       = 1'b1;
        prog_addr = a;
        prog_data = d;
      end
      @(posedge clk);
      #1;
      edges++;
      prog_we = 1'b0;
      run     = 1'b0;
    end
  endtask

  logic [DATA_W-1:0] jops [2];
  logic [DATA_W-1:0] exp_br;
  int e;

  initial begin
    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    jops[0] = 8'h79;
    jops[1] = 8'h89;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data",  {24'd0, out_data}, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'h0);
    check("rst_busy",      {31'd0, busy}, 32'h0);
    check("rst_halted",    {31'd0, halted}, 32'h0);
    check("rst_cf",        {31'd0, cf}, 32'h0);
    check("rst_zf",        {31'd0, zf}, 32'h0);
    rst = 1'b0;

    // Basic program: 5 + 3, OUT, HLT.
    for (int i = 0; i < 16; i++) write_ram(i[ADDR_W-1:0], 8'h00);
    load4(8'h1E, 8'h2F, 8'hE0, 8'hF0);
    write_ram(4'd14, 8'h05);
    write_ram(4'd15, 8'h03);
    sb.push_back(8'h08);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("basic_edges",  e, 14);
    check("basic_halted", {31'd0, halted}, 32'h1);
    check("basic_cf",     {31'd0, cf}, 32'h0);
    check("basic_zf",     {31'd0, zf}, 32'h0);
    check("basic_outreg", {24'd0, out_data}, 32'h08);

    // SUB with borrow: 3 - 5.
    load4(8'h53, 8'h3F, 8'hE0, 8'hF0);
    write_ram(4'd15, 8'h05);
    sb.push_back(8'hFE);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("sub_edges", e, 13);
    check("sub_cf",    {31'd0, cf}, 32'h0);
    check("sub_zf",    {31'd0, zf}, 32'h0);

    // ADD wrap: FF + 01.
    load4(8'h1E, 8'h2F, 8'hE0, 8'hF0);
    write_ram(4'd14, 8'hFF);
    write_ram(4'd15, 8'h01);
    sb.push_back(8'h00);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("add_edges", e, 14);
    check("add_cf",    {31'd0, cf}, 32'h1);
    check("add_zf",    {31'd0, zf}, 32'h1);

    // JC 9 / JZ 9 after FF+01 (cf=zf=1): target prints 2, fall-through prints 1.
`ifdef PARAM_SAP_CPU_BRANCH_EN
    exp_br = 8'h02;
`else
    exp_br = 8'h01;
`endif
    write_ram(4'd4,  8'hE0);
    write_ram(4'd5,  8'hF0);
    write_ram(4'd9,  8'h52);
    write_ram(4'd10, 8'hE0);
    write_ram(4'd11, 8'hF0);
    for (int k = 0; k < 2; k++) begin
      load4(8'h1E, 8'h2F, jops[k], 8'h51);
      sb.push_back(exp_br);
      run_prog(LIMIT, 4'd0, 8'h00, e);
      check("branch_edges", e, 20);
      check("branch_cf",    {31'd0, cf}, 32'h1);
    end

    // JZ with zf=0 (3 - 1 = 2) never branches.
    load4(8'h53, 8'h3F, 8'h89, 8'h51);
    sb.push_back(8'h01);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("jz_nt_edges", e, 19);
    check("jz_nt_cf",    {31'd0, cf}, 32'h1);
    check("jz_nt_zf",    {31'd0, zf}, 32'h0);

    // PC wrap: build HLT at 0 via STA, run through 15, wrap to 0.
    write_ram(4'd0, 8'h1D);
    write_ram(4'd1, 8'h2E);
    for (int i = 2; i < 13; i++) write_ram(i[ADDR_W-1:0], 8'h00);
    write_ram(4'd13, 8'hB0);
    write_ram(4'd14, 8'h40);
    write_ram(4'd15, 8'h00);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("wrap_edges",  e, 54);
    check("wrap_halted", {31'd0, halted}, 32'h1);
    check("wrap_cf",     {31'd0, cf}, 32'h0);

    // Reset during EX2 of STA 14; the store must not land.
    load4(8'h57, 8'h4E, 8'hF0, 8'hF0);
    write_ram(4'd14, 8'h05);
    write_ram(4'd15, 8'h03);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("sta_busy", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy",     {31'd0, busy}, 32'h0);
    check("mid_rst_halted",   {31'd0, halted}, 32'h0);
    check("mid_rst_out_data", {24'd0, out_data}, 32'h0);
    check("mid_rst_valid",    {31'd0, out_valid}, 32'h0);
    rst = 1'b0;
    load4(8'h1E, 8'h2F, 8'hE0, 8'hF0);
    sb.push_back(8'h08);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("post_rst_edges", e, 14);

    // Write and run while busy are ignored.
    sb.push_back(8'h08);
    run_prog(5, 4'd14, 8'h77, e);
    check("busy_run_edges", e, 14);
    sb.push_back(8'h08);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("busy_we_edges", e, 14);

    // Write in HALT lands.
    write_ram(4'd14, 8'h77);
    sb.push_back(8'h7A);
    run_prog(LIMIT, 4'd0, 8'h00, e);
    check("halt_we_edges", e, 14);

    // Simultaneous write and run: first fetch sees the new word.
    sb.push_back(8'h13);
    run_prog(-1, 4'd14, 8'h10, e);
    check("we_run_edges", e, 14);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
